// File: rtl/sync_debounce.sv
// sync_debounce
//   Per-channel synchronizer, debounce filter and edge detector for
//   asynchronous raw inputs such as switches and keys.
//
// Parameters
//   WIDTH     : number of independent channels (>= 1)
//   STAGES    : synchronizer flop depth per channel (>= 2)
//   DB_CYCLES : consecutive stable cycles needed to accept a new level
//               (1..65535)
//
// Ports
//   clock  : single clock; every flop uses its rising edge
//   reset  : asynchronous active-low reset; clears every flop
//   d      : raw asynchronous inputs
//   sync_q : last synchronizer stage per channel (not debounced)
//   level  : debounced, synchronized level per channel
//   rise   : one-cycle registered pulse when level goes 0->1
//   fall   : one-cycle registered pulse when level goes 1->0
module sync_debounce #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned STAGES    = 2,
   parameter int unsigned DB_CYCLES = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] sync_q,
   output logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   // Counter only has to reach DB_CYCLES-1, so it never wraps.
   localparam int unsigned    CW       = $clog2(DB_CYCLES) + 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

   // Stage 0 samples d; stage STAGES-1 is the synchronized output.
   logic [STAGES-1:0][WIDTH-1:0] sync_chain_q;

   logic [CW-1:0]    cnt_q [WIDTH];
   logic [CW-1:0]    cnt_d [WIDTH];
   logic [WIDTH-1:0] level_q, level_d;
   logic [WIDTH-1:0] rise_q,  rise_d;
   logic [WIDTH-1:0] fall_q,  fall_d;

   // ------------------------------------------------------------------
   // Synchronizer chain
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_chain_q <= '0;
      end else begin
         sync_chain_q <= {sync_chain_q[STAGES-2:0], d};
      end
   end

   assign sync_q = sync_chain_q[STAGES-1];

   // ------------------------------------------------------------------
   // Debounce filter and edge detection
   //   A mismatch between sync_q and level counts up; the edge on which
   //   the count already sits at DB_CYCLES-1 accepts the new level.  Any
   //   agreement clears the count so glitches never accumulate.  The
   //   rise/fall pulses are computed from the acceptance itself, so they
   //   are registered together with the new level and appear in exactly
   //   the cycle level first shows its new value.
   // ------------------------------------------------------------------
   always_comb begin
      level_d = level_q;
      rise_d  = '0;
      fall_d  = '0;
      cnt_d   = '{default: '0};
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (sync_q[i] != level_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               level_d[i] = sync_q[i];
               rise_d[i]  = sync_q[i];
               fall_d[i]  = ~sync_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q   <= '{default: '0};
         level_q <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule

// File: tb/tb_sync_debounce.sv
// tb_sync_debounce
//   Self-checking bench for sync_debounce.  Main instance uses the
//   default parameters (WIDTH=4, STAGES=2, DB_CYCLES=4); a second
//   single-channel instance (STAGES=3, DB_CYCLES=1) covers the
//   no-filtering case.  Expected output vectors are pushed to a queue
//   from the applied stimulus and popped once per clock.
module tb_sync_debounce;

   logic       clock;
   logic       reset;
   logic [3:0] d;
   logic [3:0] sync_q, level, rise, fall;

   logic [0:0] d1;
   logic [0:0] sync1, level1, rise1, fall1;

   typedef struct {
      logic [3:0] s;
      logic [3:0] l;
      logic [3:0] r;
      logic [3:0] f;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   // dstim[k] is the value of d held before edge k; dstim[0] is the
   // value that was applied before the scenario started.
   logic [3:0] dstim [0:40];

   sync_debounce #(
      .WIDTH    (4),
      .STAGES   (2),
      .DB_CYCLES(4)
   ) u_dut (
      .clock (clock),
      .reset (reset),
      .d     (d),
      .sync_q(sync_q),
      .level (level),
      .rise  (rise),
      .fall  (fall)
   );

   sync_debounce #(
      .WIDTH    (1),
      .STAGES   (3),
      .DB_CYCLES(1)
   ) u_dut1 (
      .clock (clock),
      .reset (reset),
      .d     (d1),
      .sync_q(sync1),
      .level (level1),
      .rise  (rise1),
      .fall  (fall1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance one rising edge and settle away from it.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset();
      reset = 1'b0;
      d     = 4'hF;
      d1    = 1'b1;
      #2;
      checks++;
      if ({sync_q, level, rise, fall, sync1, level1, rise1, fall1} !== 20'h0) begin
         failures++;
         $display("FAIL reset_immediate got sync=%h level=%h rise=%h fall=%h u1=%b%b%b%b expected all 0",
                  sync_q, level, rise, fall, sync1, level1, rise1, fall1);
      end
      for (int k = 1; k <= 4; k++) begin
         step();
         checks++;
         if ({sync_q, level, rise, fall, sync1, level1, rise1, fall1} !== 20'h0) begin
            failures++;
            $display("FAIL reset_hold k=%0d got sync=%h level=%h rise=%h fall=%h u1=%b%b%b%b expected all 0",
                     k, sync_q, level, rise, fall, sync1, level1, rise1, fall1);
         end
         d  = ~d;
         d1 = ~d1;
      end
      d  = 4'h0;
      d1 = 1'b0;
      step();
      reset = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step();
         checks++;
         if ({sync_q, level, rise, fall, sync1, level1, rise1, fall1} !== 20'h0) begin
            failures++;
            $display("FAIL reset_release k=%0d got sync=%h level=%h rise=%h fall=%h expected all 0",
                     k, sync_q, level, rise, fall);
         end
      end
   endtask

   // ------------------------------------------------------------------
   // Channel 0 rises and is accepted after STAGES+DB_CYCLES = 6 edges,
   // then falls back with the same latency.
   task automatic test_single();
      exp_t e;
      dstim[0] = 4'h0;
      for (int k = 1; k <= 10; k++) begin
         dstim[k] = 4'h1;
         e.s = dstim[k-1];
         e.l = (k >= 6) ? 4'h1 : 4'h0;
         e.r = (k == 6) ? 4'h1 : 4'h0;
         e.f = 4'h0;
         sb.push_back(e);
      end
      for (int k = 1; k <= 10; k++) begin
         d = dstim[k];
         step();
         e = sb.pop_front();
         checks++;
         if ({sync_q, level, rise, fall} !== {e.s, e.l, e.r, e.f}) begin
            failures++;
            $display("FAIL single_rise k=%0d got s=%h l=%h r=%h f=%h expected s=%h l=%h r=%h f=%h",
                     k, sync_q, level, rise, fall, e.s, e.l, e.r, e.f);
         end
      end
      dstim[0] = 4'h1;
      for (int k = 1; k <= 10; k++) begin
         dstim[k] = 4'h0;
         e.s = dstim[k-1];
         e.l = (k < 6) ? 4'h1 : 4'h0;
         e.r = 4'h0;
         e.f = (k == 6) ? 4'h1 : 4'h0;
         sb.push_back(e);
      end
      for (int k = 1; k <= 10; k++) begin
         d = dstim[k];
         step();
         e = sb.pop_front();
         checks++;
         if ({sync_q, level, rise, fall} !== {e.s, e.l, e.r, e.f}) begin
            failures++;
            $display("FAIL single_fall k=%0d got s=%h l=%h r=%h f=%h expected s=%h l=%h r=%h f=%h",
                     k, sync_q, level, rise, fall, e.s, e.l, e.r, e.f);
         end
      end
   endtask

   // ------------------------------------------------------------------
   // Channel 1 high for DB_CYCLES-1 = 3 cycles: sync pulses, level holds.
   task automatic test_glitch();
      exp_t e;
      dstim[0] = 4'h0;
      for (int k = 1; k <= 10; k++) begin
         dstim[k] = (k <= 3) ? 4'h2 : 4'h0;
         e.s = dstim[k-1];
         e.l = 4'h0;
         e.r = 4'h0;
         e.f = 4'h0;
         sb.push_back(e);
      end
      for (int k = 1; k <= 10; k++) begin
         d = dstim[k];
         step();
         e = sb.pop_front();
         checks++;
         if ({sync_q, level, rise, fall} !== {e.s, e.l, e.r, e.f}) begin
            failures++;
            $display("FAIL glitch k=%0d got s=%h l=%h r=%h f=%h expected s=%h l=%h r=%h f=%h",
                     k, sync_q, level, rise, fall, e.s, e.l, e.r, e.f);
         end
      end
   endtask

   // ------------------------------------------------------------------
   // Channel 1 high for exactly DB_CYCLES = 4 cycles: accepted, then the
   // return to 0 is accepted too; rise and fall end up 4 cycles apart.
   task automatic test_threshold();
      exp_t e;
      dstim[0] = 4'h0;
      for (int k = 1; k <= 14; k++) begin
         dstim[k] = (k <= 4) ? 4'h2 : 4'h0;
         e.s = dstim[k-1];
         e.l = (k >= 6 && k < 10) ? 4'h2 : 4'h0;
         e.r = (k == 6)  ? 4'h2 : 4'h0;
         e.f = (k == 10) ? 4'h2 : 4'h0;
         sb.push_back(e);
      end
      for (int k = 1; k <= 14; k++) begin
         d = dstim[k];
         step();
         e = sb.pop_front();
         checks++;
         if ({sync_q, level, rise, fall} !== {e.s, e.l, e.r, e.f}) begin
            failures++;
            $display("FAIL threshold k=%0d got s=%h l=%h r=%h f=%h expected s=%h l=%h r=%h f=%h",
                     k, sync_q, level, rise, fall, e.s, e.l, e.r, e.f);
         end
      end
   endtask

   // ------------------------------------------------------------------
   // Channel 2 toggles every cycle for 20 cycles: never accepted.
   task automatic test_toggle();
      exp_t e;
      dstim[0] = 4'h0;
      for (int k = 1; k <= 26; k++) begin
         dstim[k] = (k <= 20 && (k % 2) == 1) ? 4'h4 : 4'h0;
         e.s = dstim[k-1];
         e.l = 4'h0;
         e.r = 4'h0;
         e.f = 4'h0;
         sb.push_back(e);
      end
      for (int k = 1; k <= 26; k++) begin
         d = dstim[k];
         step();
         e = sb.pop_front();
         checks++;
         if ({sync_q, level, rise, fall} !== {e.s, e.l, e.r, e.f}) begin
            failures++;
            $display("FAIL toggle k=%0d got s=%h l=%h r=%h f=%h expected s=%h l=%h r=%h f=%h",
                     k, sync_q, level, rise, fall, e.s, e.l, e.r, e.f);
         end
      end
   endtask

   // ------------------------------------------------------------------
   // All four channels switch together, up then down.
   task automatic test_all_channels();
      exp_t e;
      dstim[0] = 4'h0;
      for (int k = 1; k <= 8; k++) begin
         dstim[k] = 4'hF;
         e.s = dstim[k-1];
         e.l = (k >= 6) ? 4'hF : 4'h0;
         e.r = (k == 6) ? 4'hF : 4'h0;
         e.f = 4'h0;
         sb.push_back(e);
      end
      dstim[9] = 4'h0;
      for (int k = 10; k <= 16; k++) dstim[k] = 4'h0;
      for (int k = 9; k <= 16; k++) begin
         e.s = dstim[k-1];
         e.l = (k < 14) ? 4'hF : 4'h0;
         e.r = 4'h0;
         e.f = (k == 14) ? 4'hF : 4'h0;
         sb.push_back(e);
      end
      for (int k = 1; k <= 16; k++) begin
         d = dstim[k];
         step();
         e = sb.pop_front();
         checks++;
         if ({sync_q, level, rise, fall} !== {e.s, e.l, e.r, e.f}) begin
            failures++;
            $display("FAIL all_channels k=%0d got s=%h l=%h r=%h f=%h expected s=%h l=%h r=%h f=%h",
                     k, sync_q, level, rise, fall, e.s, e.l, e.r, e.f);
         end
      end
   endtask

   // ------------------------------------------------------------------
   // DB_CYCLES=1, STAGES=3: sync_q is d delayed 2 edges after its first
   // stage capture, level follows sync_q one edge later, nothing filtered.
   task automatic test_db1();
      exp_t       e;
      logic [15:0] pat;
      logic       dv [0:30];
      pat = 16'b0100_1101_1000_1011;
      // dv[j+4] holds the d1 value applied before edge j; j <= 0 is idle 0.
      for (int j = 0; j <= 30; j++) dv[j] = 1'b0;
      for (int j = 1; j <= 16; j++) dv[j+4] = pat[j-1];
      for (int k = 1; k <= 22; k++) begin
         e.s = {3'b000, dv[k+2]};
         e.l = {3'b000, dv[k+1]};
         e.r = {3'b000, dv[k+1] & ~dv[k]};
         e.f = {3'b000, ~dv[k+1] & dv[k]};
         sb.push_back(e);
      end
      for (int k = 1; k <= 22; k++) begin
         d1 = dv[k+4];
         step();
         e = sb.pop_front();
         checks++;
         if ({sync1, level1, rise1, fall1} !== {e.s[0], e.l[0], e.r[0], e.f[0]}) begin
            failures++;
            $display("FAIL db1 k=%0d got s=%b l=%b r=%b f=%b expected s=%b l=%b r=%b f=%b",
                     k, sync1, level1, rise1, fall1, e.s[0], e.l[0], e.r[0], e.f[0]);
         end
      end
      d1 = 1'b0;
   endtask

   // ------------------------------------------------------------------
   // Reset mid-count discards the count; after release the full
   // STAGES+DB_CYCLES latency applies again.
   task automatic test_reset_mid_count();
      exp_t e;
      dstim[0] = 4'h0;
      for (int k = 1; k <= 4; k++) begin
         dstim[k] = 4'h8;
         e.s = dstim[k-1];
         e.l = 4'h0;
         e.r = 4'h0;
         e.f = 4'h0;
         sb.push_back(e);
      end
      for (int k = 1; k <= 4; k++) begin
         d = dstim[k];
         step();
         e = sb.pop_front();
         checks++;
         if ({sync_q, level, rise, fall} !== {e.s, e.l, e.r, e.f}) begin
            failures++;
            $display("FAIL mid_before k=%0d got s=%h l=%h r=%h f=%h expected s=%h l=%h r=%h f=%h",
                     k, sync_q, level, rise, fall, e.s, e.l, e.r, e.f);
         end
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({sync_q, level, rise, fall} !== 16'h0) begin
         failures++;
         $display("FAIL mid_async_clear got s=%h l=%h r=%h f=%h expected all 0",
                  sync_q, level, rise, fall);
      end
      for (int k = 1; k <= 2; k++) begin
         step();
         checks++;
         if ({sync_q, level, rise, fall} !== 16'h0) begin
            failures++;
            $display("FAIL mid_in_reset k=%0d got s=%h l=%h r=%h f=%h expected all 0",
                     k, sync_q, level, rise, fall);
         end
      end
      reset = 1'b1;
      dstim[0] = 4'h0;
      for (int k = 1; k <= 8; k++) begin
         dstim[k] = 4'h8;
         e.s = dstim[k-1];
         e.l = (k >= 6) ? 4'h8 : 4'h0;
         e.r = (k == 6) ? 4'h8 : 4'h0;
         e.f = 4'h0;
         sb.push_back(e);
      end
      for (int k = 1; k <= 8; k++) begin
         d = dstim[k];
         step();
         e = sb.pop_front();
         checks++;
         if ({sync_q, level, rise, fall} !== {e.s, e.l, e.r, e.f}) begin
            failures++;
            $display("FAIL mid_after k=%0d got s=%h l=%h r=%h f=%h expected s=%h l=%h r=%h f=%h",
                     k, sync_q, level, rise, fall, e.s, e.l, e.r, e.f);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_glitch();
      test_threshold();
      test_toggle();
      test_all_channels();
      test_db1();
      test_reset_mid_count();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sync_debounce.md
SYNC_DEBOUNCE -- requirements
Module: sync_debounce

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of independent input channels (>=1).
REQ-002 SHALL have parameter STAGES, default 2, synchronizer flop depth per channel (>=2).
REQ-003 SHALL have parameter DB_CYCLES, default 4, consecutive stable cycles required to accept a new level (1..65535).
REQ-004 SHALL have port clock  input  1  single clock; all flops on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port d  input  WIDTH  asynchronous raw inputs (switches, keys).
REQ-007 SHALL have port sync_q  output  WIDTH  last synchronizer stage per channel, undebounced.
REQ-008 SHALL have port level  output  WIDTH  debounced, synchronized level per channel.
REQ-009 SHALL have port rise  output  WIDTH  one-cycle pulse on level 0->1 per channel.
REQ-010 SHALL have port fall  output  WIDTH  one-cycle pulse on level 1->0 per channel.

Function
REQ-011 SHALL pass each d[i] through a chain of STAGES flops; sync_q[i] = final stage; d to sync_q latency exactly STAGES edges.
REQ-012 SHALL keep one debounce counter per channel, width ceil(log2(DB_CYCLES))+1 bits, saturating never needed, never wraps.
REQ-013 At each edge with sync_q[i] == level[i]: counter[i] <= 0, level[i] unchanged.
REQ-014 At each edge with sync_q[i] != level[i] and counter[i] < DB_CYCLES-1: counter[i] <= counter[i]+1, level[i] unchanged.
REQ-015 At each edge with sync_q[i] != level[i] and counter[i] == DB_CYCLES-1: level[i] <= sync_q[i], counter[i] <= 0.
REQ-016 Consequence: level[i] changes on the DB_CYCLES-th edge after sync_q[i] changes, provided sync_q[i] holds; total d to level latency STAGES+DB_CYCLES edges.
REQ-017 DB_CYCLES=1: level[i] follows sync_q[i] with one edge lag, no filtering.
REQ-018 Any return of sync_q[i] to level[i] before acceptance SHALL clear counter[i]; partial counts never accumulate across glitches.
REQ-019 rise[i] SHALL be registered, high for exactly the cycle in which level[i] first reads 1 after reading 0; fall[i] likewise for 1->0.
REQ-020 rise[i] and fall[i] SHALL never be high simultaneously; back-to-back pulses on one channel SHALL be separated by at least DB_CYCLES cycles.
REQ-021 Channels SHALL be fully independent; simultaneous transitions on any subset of channels produce simultaneous pulses on that subset.
REQ-022 No combinational path from d to any output.

Reset
REQ-023 reset low SHALL immediately (asynchronously) clear all synchronizer flops, counters, level, rise, fall to 0.
REQ-024 While reset low, all outputs SHALL stay 0 regardless of d.
REQ-025 Release of reset SHALL not itself generate rise or fall pulses; a channel with d=1 at release yields rise after STAGES+DB_CYCLES edges.
REQ-026 reset asserted mid-count SHALL discard the count; counting restarts from 0 after release.

Verification (WIDTH=4, STAGES=2, DB_CYCLES=4)
REQ-027 Reset low with d=4'hF -> sync_q, level, rise, fall all 4'h0 immediately and throughout reset, no clock needed.
REQ-028 Release reset, d=4'h0, then d[0] 0->1 held -> sync_q[0]=1 after 2 edges, level[0]=1 and rise[0]=1 for one cycle after 6 edges, rise[0]=0 thereafter.
REQ-029 With level[1]=0, d[1] high for 3 cycles then low -> sync_q[1] pulses 3 cycles, level[1] stays 0, rise[1] never asserts.
REQ-030 d[2] toggled every cycle for 20 cycles, then held 0 -> level[2], rise[2], fall[2] remain 0.
REQ-031 All four channels 0->1 same cycle -> rise=4'hF for one cycle 6 edges later; then d=4'h0 -> fall=4'hF for one cycle 6 edges later.
REQ-032 d[3] 0->1, reset pulsed low after 4 edges, released, d[3] held 1 -> no rise before reset; rise[3] exactly 6 edges after release.
